// File: rtl/hps_pixel_fifo_bridge_if.sv
// Pixel stream + Avalon-MM bus bundle for hps_pixel_fifo_bridge.
// master: camera source and HPS side (drives pix_*, address, read, write, writedata).
// slave : the bridge (drives pix_ready, readdata, waitrequest).
interface hps_pixel_fifo_bridge_if #(
  parameter int PIX_W = 24
);
  logic             pix_valid;
  logic [PIX_W-1:0] pix_data;
  logic             pix_last;
  logic             pix_ready;
  logic [2:0]       address;
  logic             read;
  logic [31:0]      readdata;
  logic             write;
  logic [31:0]      writedata;
  logic             waitrequest;

  modport master (
    output pix_valid, pix_data, pix_last, address, read, write, writedata,
    input  pix_ready, readdata, waitrequest
  );

  modport slave (
    input  pix_valid, pix_data, pix_last, address, read, write, writedata,
    output pix_ready, readdata, waitrequest
  );
endinterface

// File: rtl/hps_pixel_fifo_bridge.sv
// hps_pixel_fifo_bridge: Avalon-MM slave moving camera pixels to the HPS
// through a DEPTH-entry FIFO, one CPU read per pixel.
// Ports:
//   clk, rst_n  clock and synchronous active-low reset
//   bus         pixel valid/ready stream in, Avalon-MM slave (read latency 1)
//   frame_irq   level interrupt = frame_done & irq_en
//   out_state   FSM state for debug (0 IDLE, 1 STREAM, 2 DRAIN, 3 DONE)
// Registers: 0 STATUS, 1 CONTROL, 2 DATA (read pops), 3 PIXCOUNT.
module hps_pixel_fifo_bridge #(
  parameter int PIX_W = 24,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  hps_pixel_fifo_bridge_if.slave bus,
  output logic                   frame_irq,
  output logic [1:0]             out_state
);

  localparam int AW    = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t           state;
  logic [PIX_W:0]   mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [LVL_W-1:0] level;
  logic [31:0]      pixcount;
  logic             enable, irq_en, frame_done, underflow;

  logic           full, empty, push, pop, ctrl_wr, clr, data_rd, restart;
  logic [PIX_W:0] head;
  logic           head_last;
  logic [31:0]    rd_mux;

  assign full      = (level == LVL_W'(DEPTH));
  assign empty     = (level == '0);
  assign head      = mem[rd_ptr];
  assign head_last = head[PIX_W];

  assign bus.pix_ready   = (state == STREAM) && !full;
  assign bus.waitrequest = 1'b0;
  assign push    = bus.pix_valid && bus.pix_ready;
  assign ctrl_wr = bus.write && (bus.address == 3'd1);
  assign clr     = ctrl_wr && bus.writedata[1];
  assign data_rd = bus.read && (bus.address == 3'd2);
  // An empty read never pops: no bypass from a same-cycle push.
  assign pop     = data_rd && !empty;
  assign restart = ctrl_wr && bus.writedata[0] && (state == DONE);

  assign frame_irq = frame_done && irq_en;
  assign out_state = state;

  // Read mux sees pre-edge state, so a same-cycle write is not visible.
  always_comb begin
    rd_mux = '0;
    case (bus.address)
      3'd0: begin
        rd_mux[0]     = !empty;
        rd_mux[1]     = frame_done;
        rd_mux[2]     = underflow;
        rd_mux[31:16] = 16'(level);
      end
      3'd1: rd_mux = {29'd0, irq_en, 1'b0, enable};
      3'd2: begin
        if (!empty) begin
          rd_mux     = 32'(head[PIX_W-1:0]);
          rd_mux[31] = head_last;
        end
      end
      3'd3: rd_mux = pixcount;
      default: rd_mux = '0;
    endcase
  end

  // Storage is not reset; contents are meaningless once pointers are flushed.
  always_ff @(posedge clk) begin
    if (push && !clr) mem[wr_ptr] <= {bus.pix_last, bus.pix_data};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level        <= '0;
      pixcount     <= '0;
      enable       <= 1'b0;
      irq_en       <= 1'b0;
      frame_done   <= 1'b0;
      underflow    <= 1'b0;
      bus.readdata <= '0;
    end else begin
      if (bus.read) bus.readdata <= rd_mux;

      if (ctrl_wr) begin
        enable <= bus.writedata[0];
        irq_en <= bus.writedata[2];
      end

      if (clr) begin
        // Clear beats any same-cycle push/pop; the pushed pixel is dropped.
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        level      <= '0;
        pixcount   <= '0;
        frame_done <= 1'b0;
        underflow  <= 1'b0;
        state      <= bus.writedata[0] ? STREAM : IDLE;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        if (push && !pop)      level <= level + LVL_W'(1);
        else if (pop && !push) level <= level - LVL_W'(1);

        if (data_rd && empty)                 underflow <= 1'b1;
        else if (ctrl_wr && bus.writedata[3]) underflow <= 1'b0;

        if (restart)  pixcount <= '0;
        else if (pop) pixcount <= pixcount + 32'd1;

        if (restart)                                 frame_done <= 1'b0;
        else if (state == DRAIN && pop && head_last) frame_done <= 1'b1;

        if (ctrl_wr && !bus.writedata[0]) begin
          state <= IDLE;
        end else begin
          case (state)
            IDLE:    if (ctrl_wr) state <= STREAM;
            STREAM:  if (push && bus.pix_last) state <= DRAIN;
            DRAIN:   if (pop && head_last) state <= DONE;
            DONE:    if (ctrl_wr) state <= STREAM;
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_hps_pixel_fifo_bridge.sv
module tb_hps_pixel_fifo_bridge;
  localparam int PIX_W = 24;
  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       frame_irq;
  logic [1:0] out_state;

  hps_pixel_fifo_bridge_if #(.PIX_W(PIX_W)) bus ();

  hps_pixel_fifo_bridge #(.PIX_W(PIX_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .frame_irq (frame_irq),
    .out_state (out_state)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: FIFO as a queue of {last, pixel}, spec states as ints.
  logic [PIX_W:0] m_fifo [$];
  logic [31:0]    exp_q [$];
  logic [31:0]    m_pc;
  int             m_state;
  bit             m_en, m_irq_en, m_fd, m_uf, m_rd, started;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_fifo.delete();
    exp_q.delete();
    m_pc = 0; m_state = 0;
    m_en = 0; m_irq_en = 0; m_fd = 0; m_uf = 0; m_rd = 0;
  endtask

  task automatic model_step();
    logic [31:0]    rd;
    logic [PIX_W:0] e;
    int  sz, nst;
    bit  push, dr, ctrl_wr, clr;
    started = 1;
    m_rd = 0;
    if (!rst_n) begin
      model_reset();
      return;
    end
    sz      = m_fifo.size();
    push    = bus.pix_valid && (m_state == 1) && (sz < DEPTH);
    dr      = bus.read && (bus.address == 3'd2);
    ctrl_wr = bus.write && (bus.address == 3'd1);
    clr     = ctrl_wr && bus.writedata[1];
    if (bus.read) begin
      case (bus.address)
        3'd0: rd = {16'(sz), 13'd0, m_uf, m_fd, (sz > 0)};
        3'd1: rd = {29'd0, m_irq_en, 1'b0, m_en};
        3'd2: rd = (sz == 0) ? 32'd0 : {m_fifo[0][PIX_W], 7'd0, m_fifo[0][PIX_W-1:0]};
        3'd3: rd = m_pc;
        default: rd = 32'd0;
      endcase
      exp_q.push_back(rd);
      m_rd = 1;
    end
    nst = m_state;
    if (clr) begin
      m_fifo.delete();
      m_pc = 0; m_fd = 0; m_uf = 0;
      nst = bus.writedata[0] ? 1 : 0;
    end else begin
      if (dr && sz > 0) begin
        e = m_fifo.pop_front();
        m_pc = m_pc + 1;
        if (m_state == 2 && e[PIX_W]) begin m_fd = 1; nst = 3; end
      end
      if (push) begin
        m_fifo.push_back({bus.pix_last, bus.pix_data});
        if (bus.pix_last) nst = 2;
      end
      if (dr && sz == 0) m_uf = 1;
      else if (ctrl_wr && bus.writedata[3]) m_uf = 0;
      if (ctrl_wr) begin
        if (!bus.writedata[0]) nst = 0;
        else if (m_state == 0) nst = 1;
        else if (m_state == 3) begin nst = 1; m_pc = 0; m_fd = 0; end
      end
    end
    if (ctrl_wr) begin
      m_en     = bus.writedata[0];
      m_irq_en = bus.writedata[2];
    end
    m_state = nst;
  endtask

  initial begin
    model_reset();
    started = 0;
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // Monitor: compares read responses and per-cycle outputs against the model.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (started) begin
        if (m_rd) begin
          if (exp_q.size() == 0) begin
            chk("readdata_unexpected", bus.readdata, 32'hxxxx_xxxx);
          end else begin
            e = exp_q.pop_front();
            chk("readdata", bus.readdata, e);
          end
        end
        chk("pix_ready", 32'(bus.pix_ready), 32'((m_state == 1) && (m_fifo.size() < DEPTH)));
        chk("frame_irq", 32'(frame_irq), 32'(m_fd && m_irq_en));
        chk("out_state", 32'(out_state), 32'(m_state));
        chk("waitrequest", 32'(bus.waitrequest), 32'd0);
      end
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic drive_idle();
    bus.pix_valid = 0; bus.pix_data = '0; bus.pix_last = 0;
    bus.address = 3'd0; bus.read = 0; bus.write = 0; bus.writedata = '0;
  endtask

  task automatic cpu_rd(input logic [2:0] a);
    bus.address = a; bus.read = 1;
    cyc();
    bus.read = 0;
  endtask

  task automatic cpu_wr(input logic [2:0] a, input logic [31:0] d);
    bus.address = a; bus.write = 1; bus.writedata = d;
    cyc();
    bus.write = 0;
  endtask

  task automatic push_px(input logic [PIX_W-1:0] d, input logic l);
    bit ok = 0;
    bus.pix_valid = 1; bus.pix_data = d; bus.pix_last = l;
    for (int n = 0; n < 40 && !ok; n++) begin
      ok = bus.pix_ready;
      cyc();
    end
    bus.pix_valid = 0; bus.pix_last = 0;
    chk("push_accepted", 32'(ok), 32'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_readdata"}, bus.readdata, 32'd0);
    chk({tag, "_pix_ready"}, 32'(bus.pix_ready), 32'd0);
    chk({tag, "_out_state"}, 32'(out_state), 32'd0);
    chk({tag, "_frame_irq"}, 32'(frame_irq), 32'd0);
    chk({tag, "_waitrequest"}, 32'(bus.waitrequest), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pushes;
    logic [31:0] wd;
    rst_n = 0;
    drive_idle();
    repeat (3) cyc();
    rst_n = 1;
    chk_reset_outputs("reset");
    cpu_rd(3'd0);
    chk("reset_status", bus.readdata, 32'd0);

    // Three-pixel frame
    cpu_wr(3'd1, 32'h1);
    push_px(24'h112233, 0);
    push_px(24'h445566, 0);
    push_px(24'h778899, 1);
    chk("t1_ready_low", 32'(bus.pix_ready), 32'd0);
    chk("t1_drain", 32'(out_state), 32'd2);
    cpu_rd(3'd0); chk("t1_status", bus.readdata, 32'h0003_0001);
    cpu_rd(3'd2); chk("t1_pix0", bus.readdata, 32'h0011_2233);
    cpu_rd(3'd2); chk("t1_pix1", bus.readdata, 32'h0044_5566);
    cpu_rd(3'd2); chk("t1_pix2", bus.readdata, 32'h8077_8899);
    cpu_rd(3'd0); chk("t1_status_done", bus.readdata, 32'h0000_0002);
    cpu_rd(3'd3); chk("t1_pixcount", bus.readdata, 32'd3);

    // Underflow on empty read, pixcount untouched
    cpu_rd(3'd2); chk("uf_data", bus.readdata, 32'd0);
    cpu_rd(3'd0); chk("uf_status", bus.readdata, 32'h0000_0006);
    cpu_rd(3'd3); chk("uf_pixcount", bus.readdata, 32'd3);
    cpu_wr(3'd1, 32'h9);
    cpu_rd(3'd0); chk("uf_cleared", bus.readdata, 32'd0);
    chk("uf_stream", 32'(out_state), 32'd1);

    // Fill to DEPTH with no reads
    pushes = 0;
    bus.pix_valid = 1; bus.pix_last = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.pix_ready) pushes++;
      bus.pix_data = 24'($urandom);
      cyc();
    end
    chk("full_pushes", 32'(pushes), 32'd16);
    chk("full_ready_low", 32'(bus.pix_ready), 32'd0);
    bus.address = 3'd2; bus.read = 1;
    cyc();
    bus.read = 0;
    chk("full_ready_after_pop", 32'(bus.pix_ready), 32'd1);
    cyc();
    chk("full_17th_taken", 32'(bus.pix_ready), 32'd0);
    bus.pix_valid = 0;
    cpu_rd(3'd0); chk("full_level", bus.readdata, 32'h0010_0001);
    cpu_wr(3'd1, 32'h3);

    // Frame-done interrupt
    cpu_wr(3'd1, 32'h5);
    push_px(24'hABCDEF, 1);
    cpu_rd(3'd2);
    chk("irq_pix", bus.readdata, 32'h80AB_CDEF);
    chk("irq_high", 32'(frame_irq), 32'd1);
    chk("irq_done", 32'(out_state), 32'd3);
    cpu_wr(3'd1, 32'h5);
    chk("irq_low", 32'(frame_irq), 32'd0);
    chk("irq_restart", 32'(out_state), 32'd1);
    cpu_rd(3'd3); chk("irq_pixcount", bus.readdata, 32'd0);

    // Clear in the same cycle as a push
    for (int i = 0; i < 5; i++) push_px(24'(i + 1), 0);
    bus.pix_valid = 1; bus.pix_data = 24'hDEAD00; bus.pix_last = 0;
    bus.address = 3'd1; bus.write = 1; bus.writedata = 32'h3;
    cyc();
    bus.pix_valid = 0; bus.write = 0;
    cpu_rd(3'd0); chk("clr_status", bus.readdata, 32'd0);
    cpu_rd(3'd3); chk("clr_pixcount", bus.readdata, 32'd0);
    chk("clr_stream", 32'(out_state), 32'd1);

    // Reset mid-frame
    push_px(24'h000001, 0);
    push_px(24'h000002, 0);
    rst_n = 0;
    cyc();
    rst_n = 1;
    chk_reset_outputs("midrst");
    cpu_rd(3'd0); chk("midrst_status", bus.readdata, 32'd0);

    // Randomized traffic against the model
    cpu_wr(3'd1, 32'h5);
    for (int i = 0; i < 4000; i++) begin
      bus.pix_valid = 1'($urandom_range(0, 1));
      bus.pix_data  = 24'($urandom);
      bus.pix_last  = ($urandom_range(0, 11) == 0);
      bus.read      = ($urandom_range(0, 9) < 4);
      bus.write     = ($urandom_range(0, 19) == 0);
      if (bus.write && $urandom_range(0, 4) != 0) bus.address = 3'd1;
      else if ($urandom_range(0, 9) < 6)          bus.address = 3'd2;
      else                                        bus.address = 3'($urandom_range(0, 7));
      wd = $urandom;
      wd[0] = ($urandom_range(0, 7) != 0);
      wd[1] = ($urandom_range(0, 7) == 0);
      bus.writedata = wd;
      rst_n = ($urandom_range(0, 999) != 0);
      cyc();
    end
    drive_idle();
    rst_n = 1;
    repeat (3) cyc();
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hps_pixel_fifo_bridge.md
# hps_pixel_fifo_bridge

Parametrised Avalon-MM slave that moves pixels from the camera image reader to the HPS through a DEPTH-entry FIFO. The camera side pushes pixels with a valid/ready handshake. The CPU pops them with one read per pixel, so the CPU no longer runs a per-pixel ack handshake. Frame boundaries, fill level, underflow and a frame-done interrupt are exposed through a register map. The block sits between the D8M image reader and the HPS lightweight bridge.

## Interface
- PIX_W, 24: pixel width in bits; legal range 1..31.
- DEPTH, 16: FIFO entries; power of 2, range 2..1024.
- LVL_W, $clog2(DEPTH)+1: fill-level counter width (derived, not overridden).
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- pix_valid  in  1  source has a pixel on pix_data.
- pix_data  in  PIX_W  pixel value.
- pix_last  in  1  qualifies pix_valid; marks the final pixel of a frame.
- pix_ready  out  1  bridge accepts the pixel this cycle.
- address  in  3  Avalon word address.
- read  in  1  Avalon read strobe.
- readdata  out  32  Avalon read data; fixed read latency 1.
- write  in  1  Avalon write strobe.
- writedata  in  32  Avalon write data.
- waitrequest  out  1  tied 0; every access completes in its own cycle.
- frame_irq  out  1  level interrupt, equal to frame_done AND irq_en.
- out_state  out  2  current FSM state encoding, for debug.

## Operation
- Register map (any address not listed reads 0 and ignores writes):
  - 0 STATUS (R): bit0 not_empty; bit1 frame_done; bit2 underflow (sticky); bits[31:16] fill level, zero-extended.
  - 1 CONTROL (R/W): bit0 enable; bit1 clear, write-only and self-clearing; bit2 irq_en; bit3 clr_underflow, write-only. Reads return {29'b0, irq_en, 1'b0, enable}.
  - 2 DATA (R): readdata = {last_flag, (31-PIX_W) zeros, pixel}. A read pops one entry.
  - 3 PIXCOUNT (R): 32-bit count of entries popped since the last frame start or clear.
- FIFO entries store PIX_W+1 bits: the pixel plus pix_last.
- pix_ready = (state==STREAM) AND !full. A push occurs when pix_valid AND pix_ready.
- FSM states:
  - IDLE (0): enable=0; no pushes.
  - STREAM (1): accepts pixels.
  - DRAIN (2): the last pixel has been pushed; pix_ready=0 until that pixel is popped.
  - DONE (3): frame_done=1.
- FSM transitions:
  - IDLE -> STREAM: a CONTROL write sets enable=1.
  - STREAM -> DRAIN: a push with pix_last=1.
  - DRAIN -> DONE: a DATA read pops the entry whose last_flag=1.
  - DONE -> STREAM: a CONTROL write with enable=1. PIXCOUNT and frame_done clear on this transition.
  - Any state -> IDLE: a CONTROL write with enable=0. The FIFO is retained and can still be popped.
- clear=1 flushes the FIFO pointers and level and zeroes PIXCOUNT, frame_done and underflow. Next state is STREAM if the same write has enable=1, otherwise IDLE.
- A DATA read while empty returns 0, does not pop, does not increment PIXCOUNT, and sets underflow.
- PIXCOUNT wraps modulo 2^32.

## Timing
- Reset values:
  - State IDLE; FIFO empty; level 0; PIXCOUNT 0.
  - enable, irq_en, frame_done and underflow all 0.
  - pix_ready 0; readdata 0; frame_irq 0; out_state 0; waitrequest 0.
- Read latency: readdata is registered and is valid the cycle after read is asserted. When read=0, readdata holds its previous value.
- A pop happens in the read cycle. Level, not_empty and PIXCOUNT update on the next edge.
- STATUS and PIXCOUNT reads return the pre-edge values of the read cycle.
- Push and pop in the same cycle: level is unchanged. When the FIFO is empty, a same-cycle pop sees empty: underflow, no bypass.
- full = (level==DEPTH). pix_ready drops combinationally on the same edge that makes level reach DEPTH. It reasserts in the cycle after a pop.
- A CONTROL write takes effect on the next edge.
- Write and read in the same cycle: both are served. The read observes the pre-write state.
- clear in the same cycle as a push or pop: clear wins, and the pushed pixel is discarded.
- frame_irq rises the cycle after the last-pixel pop. It falls the cycle after clear, after irq_en=0, or after the DONE -> STREAM restart.
- rst_n low mid-frame: all state returns to reset values on that edge, and FIFO contents are lost.

## Test plan
- Reset, then enable and push 3 pixels 0x112233, 0x445566, 0x778899 (last on the third) -> pix_ready falls after the 3rd push. STATUS reads level 3, not_empty 1. Three DATA reads return 0x00112233, 0x00445566, 0x80778899. Then STATUS bit1=1 and PIXCOUNT=3.
- DEPTH=16, enabled, source holds valid, no CPU reads -> exactly 16 pushes, then pix_ready=0. One DATA read -> pix_ready=1 the next cycle and the 17th pixel is accepted.
- DATA read on an empty FIFO -> readdata 0, STATUS bit2=1, PIXCOUNT unchanged. Write CONTROL=0x9 (enable, clr_underflow) -> bit2=0.
- irq_en=1 and a frame of 1 pixel with last -> frame_irq=1 the cycle after the pop. Write CONTROL=0x5 (enable, irq_en) -> frame_irq=0, state STREAM, PIXCOUNT 0.
- Push 5 pixels, then write CONTROL=0x3 (enable, clear) in the same cycle as a push -> level 0, PIXCOUNT 0, state STREAM, pushed pixel discarded.
- Assert rst_n=0 for 1 cycle mid-frame -> every output at its reset value, out_state 0, STATUS reads 0.
